// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-I subset core. One shared datapath (ALU, register file,
// IR/A/B/ALUOut/MDR) is sequenced by a control FSM, and instruction and data
// accesses share a single req/ready memory port that tolerates wait states.
module mips_multicycle_core #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       instruction,
    output logic [31:0]       alu_out,
    output logic [31:0]       reg_write_data,
    output logic [CNT_W-1:0]  retired,
    output logic              halted
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic        retire;
    logic        transfer;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] mdr;
    logic [31:0] rf [32];

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] sext_imm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [4:0]  dest;
    logic [31:0] pc_ext;
    logic [31:0] jump_target;
    logic [31:0] alu_result;
    logic        funct_ok;
    logic        op_legal;
    logic [ADDR_W-1:0] addr_sel;

    assign op       = instruction[31:26];
    assign rs       = instruction[25:21];
    assign rt       = instruction[20:16];
    assign rd       = instruction[15:11];
    assign shamt    = instruction[10:6];
    assign funct    = instruction[5:0];
    assign sext_imm = {{16{instruction[15]}}, instruction[15:0]};

    // r0 is hard-wired to zero on the read side; writes to it are also dropped
    assign rs_val = (rs == 5'd0) ? '0 : rf[rs];
    assign rt_val = (rt == 5'd0) ? '0 : rf[rt];

    assign dest           = (op == OP_RTYPE) ? rd : rt;
    assign reg_write_data = (op == OP_LW) ? mdr : alu_out;

    // jump keeps the top nibble of pc+4; narrower PCs simply drop the high bits
    assign pc_ext      = 32'(pc);
    assign jump_target = {pc_ext[31:28], instruction[25:0], 2'b00};

    assign funct_ok = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                      (funct == F_OR)  || (funct == F_SLT) || (funct == F_SLL);
    assign op_legal = ((op == OP_RTYPE) && funct_ok) || (op == OP_LW) ||
                      (op == OP_SW) || (op == OP_BEQ) || (op == OP_ADDI);

    assign transfer  = mem_req && mem_ready;
    assign addr_sel  = (state == S_MEM) ? alu_out[ADDR_W-1:0] : pc;
    assign mem_addr  = {addr_sel[ADDR_W-1:2], 2'b00};
    assign mem_wdata = b_reg;
    assign halted    = (state == S_HALT);

    // R-type ALU operation selected by funct
    always_comb begin
        alu_result = '0;
        case (funct)
            F_ADD:   alu_result = a_reg + b_reg;
            F_SUB:   alu_result = a_reg - b_reg;
            F_AND:   alu_result = a_reg & b_reg;
            F_OR:    alu_result = a_reg | b_reg;
            F_SLT:   alu_result = {31'd0, $signed(a_reg) < $signed(b_reg)};
            F_SLL:   alu_result = b_reg << shamt;
            default: alu_result = '0;
        endcase
    end

    // control FSM sequencing and retire-event generation
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            S_FETCH: begin
                if (transfer) state_next = S_DECODE;
            end
            S_DECODE: begin
                if (op == OP_J) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end else if (op_legal) begin
                    state_next = S_EXEC;
                end else begin
                    state_next = S_HALT;
                end
            end
            S_EXEC: begin
                if (op == OP_BEQ) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end else if ((op == OP_LW) || (op == OP_SW)) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                if (transfer) begin
                    if (op == OP_SW) begin
                        state_next = S_FETCH;
                        retire     = 1'b1;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    // state, holding registers, PC, request flags and retire counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            instruction <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            alu_out     <= '0;
            mdr         <= '0;
            retired     <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
        end else begin
            state <= state_next;
            // request is registered from the next state so it is already up
            // in the first FETCH/MEM cycle and holds until the transfer edge
            mem_req <= (state_next == S_FETCH) || (state_next == S_MEM);
            mem_we  <= (state_next == S_MEM) && (op == OP_SW);
            if (retire) retired <= retired + CNT_W'(1);
            case (state)
                S_FETCH: begin
                    if (transfer) begin
                        instruction <= mem_rdata;
                        pc          <= pc + ADDR_W'(4);
                    end
                end
                S_DECODE: begin
                    a_reg   <= rs_val;
                    b_reg   <= rt_val;
                    alu_out <= pc_ext + (sext_imm << 2);
                    if (op == OP_J) pc <= jump_target[ADDR_W-1:0];
                end
                S_EXEC: begin
                    if (op == OP_RTYPE) begin
                        alu_out <= alu_result;
                    end else if ((op == OP_LW) || (op == OP_SW) || (op == OP_ADDI)) begin
                        alu_out <= a_reg + sext_imm;
                    end else if ((op == OP_BEQ) && (a_reg == b_reg)) begin
                        pc <= alu_out[ADDR_W-1:0];
                    end
                end
                S_MEM: begin
                    if (transfer && (op == OP_LW)) mdr <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // register file write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (reset && (state == S_WB) && (dest != 5'd0)) begin
            rf[dest] <= reg_write_data;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: directed programs plus random programs,
// checked against an instruction-level reference model of the ISA.
module tb_mips_multicycle_core;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned CNT_W    = 32;
    localparam logic [31:0] RESET_PC = 32'h40;
    localparam logic [31:0] HALT_OP  = 32'hFC00_0000;
    localparam int          RUN_LIMIT = 3000;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instruction;
    logic [31:0]       alu_out;
    logic [31:0]       reg_write_data;
    logic [CNT_W-1:0]  retired;
    logic              halted;

    mips_multicycle_core #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready),
        .pc             (pc),
        .instruction    (instruction),
        .alu_out        (alu_out),
        .reg_write_data (reg_write_data),
        .retired        (retired),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        logic [31:0] pc_after;
        int          cycles;
        logic [31:0] ir;
        logic        rwd_valid;
        logic [31:0] rwd;
    } retire_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mem   [1024];
    logic [31:0] mmem  [1024];
    logic [31:0] mregs [32];
    xfer_t       exp_xfer [$];
    retire_t     exp_ret  [$];
    bit          exp_halt;
    int          waits_cfg  = 0;
    bit          stall_data = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rs, input int rt,
                                          input int rd, input int sh);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic put(input logic [31:0] byte_addr, input logic [31:0] w);
        mem[byte_addr[11:2]]  = w;
        mmem[byte_addr[11:2]] = w;
    endtask

    // Instruction-level model: walks the program from RESET_PC and records every
    // expected memory transfer plus per-instruction PC, cycle cost and WB value.
    task automatic model_run(input int waits);
        logic [31:0] mpc, ir, a, b, res, addr;
        logic [5:0]  op, fn;
        int          rs, rt, rd, sh;
        retire_t     r;
        xfer_t       x;
        mpc = RESET_PC;
        exp_xfer.delete();
        exp_ret.delete();
        exp_halt = 1'b0;
        mregs[0] = '0;
        for (int step = 0; step < 500; step++) begin
            ir = mmem[mpc[11:2]];
            x = '{we: 1'b0, addr: mpc, wdata: '0};
            exp_xfer.push_back(x);
            op = ir[31:26]; fn = ir[5:0];
            rs = int'(ir[25:21]); rt = int'(ir[20:16]); rd = int'(ir[15:11]); sh = int'(ir[10:6]);
            a = mregs[rs]; b = mregs[rt];
            r.ir = ir; r.rwd_valid = 1'b0; r.rwd = '0;
            mpc = mpc + 32'd4;
            case (op)
                6'h00: begin
                    case (fn)
                        6'h20: res = a + b;
                        6'h22: res = a - b;
                        6'h24: res = a & b;
                        6'h25: res = a | b;
                        6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        6'h00: res = b << sh;
                        default: begin exp_halt = 1'b1; return; end
                    endcase
                    if (rd != 0) mregs[rd] = res;
                    r.rwd_valid = 1'b1; r.rwd = res; r.cycles = 4 + waits;
                end
                6'h08: begin
                    res = a + sext(ir[15:0]);
                    if (rt != 0) mregs[rt] = res;
                    r.rwd_valid = 1'b1; r.rwd = res; r.cycles = 4 + waits;
                end
                6'h23: begin
                    addr = (a + sext(ir[15:0])) & ~32'd3;
                    x = '{we: 1'b0, addr: addr, wdata: '0};
                    exp_xfer.push_back(x);
                    res = mmem[addr[11:2]];
                    if (rt != 0) mregs[rt] = res;
                    r.rwd_valid = 1'b1; r.rwd = res; r.cycles = 5 + 2 * waits;
                end
                6'h2B: begin
                    addr = (a + sext(ir[15:0])) & ~32'd3;
                    x = '{we: 1'b1, addr: addr, wdata: b};
                    exp_xfer.push_back(x);
                    mmem[addr[11:2]] = b;
                    r.cycles = 4 + 2 * waits;
                end
                6'h04: begin
                    if (a == b) mpc = mpc + (sext(ir[15:0]) << 2);
                    r.cycles = 3 + waits;
                end
                6'h02: begin
                    mpc = {mpc[31:28], ir[25:0], 2'b00};
                    r.cycles = 2 + waits;
                end
                default: begin exp_halt = 1'b1; return; end
            endcase
            r.pc_after = mpc;
            exp_ret.push_back(r);
        end
    endtask

    // Memory responder: completes transfers, checks them against the model and
    // checks request stability during wait states.
    initial begin
        xfer_t       x;
        int          req_age;
        logic [31:0] cap_addr, cap_wdata;
        logic        cap_we;
        req_age   = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (!reset) begin
                req_age = 0;
            end else if (mem_req && mem_ready) begin
                check("xfer_expected", 32'(exp_xfer.size() != 0), 32'd1);
                if (exp_xfer.size() != 0) begin
                    x = exp_xfer.pop_front();
                    check("xfer_we", 32'(mem_we), 32'(x.we));
                    check("xfer_addr", mem_addr, x.addr);
                    if (x.we) check("xfer_wdata", mem_wdata, x.wdata);
                end
                if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
                req_age = 0;
            end
            #1;
            if (mem_req && reset) begin
                if (req_age == 0) begin
                    cap_addr = mem_addr; cap_wdata = mem_wdata; cap_we = mem_we;
                end else begin
                    check("stable_addr", mem_addr, cap_addr);
                    check("stable_we", 32'(mem_we), 32'(cap_we));
                    if (cap_we) check("stable_wdata", mem_wdata, cap_wdata);
                end
                mem_ready = (req_age >= waits_cfg) && !(stall_data && (mem_addr != pc));
                mem_rdata = mem_ready ? mem[mem_addr[11:2]] : $urandom();
                req_age++;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom();
                req_age   = 0;
            end
        end
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b0;
        repeat (n) @(negedge clk);
        check("rst_pc", pc, RESET_PC);
        check("rst_retired", retired, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_ir", instruction, 32'd0);
        check("rst_aluout", alu_out, 32'd0);
        reset = 1'b1;
    endtask

    task automatic run_prog(input int waits);
        int          cyc, start;
        bit          started;
        logic [31:0] last_ret;
        retire_t     r;
        model_run(waits);
        waits_cfg = waits;
        do_reset(2);
        cyc = 0; start = 0; started = 1'b0; last_ret = '0;
        while ((exp_ret.size() != 0 || (exp_halt && !halted)) && cyc <= RUN_LIMIT) begin
            @(negedge clk);
            cyc++;
            if (!started && mem_req) begin
                started = 1'b1;
                start   = cyc;
            end
            if (retired != last_ret) begin
                check("retire_step", retired, last_ret + 32'd1);
                last_ret = retired;
                check("retire_expected", 32'(exp_ret.size() != 0), 32'd1);
                if (exp_ret.size() != 0) begin
                    r = exp_ret.pop_front();
                    check("pc_after", pc, r.pc_after);
                    check("cycles", 32'(cyc - start), 32'(r.cycles));
                    check("ir", instruction, r.ir);
                    if (r.rwd_valid) check("wb_data", reg_write_data, r.rwd);
                end
                start = cyc;
            end
        end
        check("run_timeout", 32'(cyc > RUN_LIMIT), 32'd0);
        if (exp_halt) begin
            check("halted", 32'(halted), 32'd1);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                check("halt_req", 32'(mem_req), 32'd0);
            end
            check("halt_retired", retired, last_ret);
        end
        check("xfers_left", 32'(exp_xfer.size()), 32'd0);
    endtask

    task automatic gen_random();
        logic [5:0]  fns [6];
        logic [31:0] a;
        int          k, rs, rt, sh;
        logic [5:0]  fn;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        for (int i = 'h100; i < 'h120; i++) begin
            mem[i]  = $urandom();
            mmem[i] = mem[i];
        end
        a = RESET_PC;
        for (int r = 1; r < 8; r++) begin
            put(a, enc_i(6'h08, 0, r, 16'($urandom()))); a += 4;
        end
        for (int n = 0; n < 24; n++) begin
            k  = int'($urandom_range(0, 5));
            rs = int'($urandom_range(0, 7));
            rt = int'($urandom_range(0, 7));
            case (k)
                0: begin
                    fn = fns[$urandom_range(0, 5)];
                    sh = (fn == 6'h00) ? int'($urandom_range(0, 31)) : 0;
                    put(a, enc_r(fn, rs, rt, int'($urandom_range(0, 7)), sh));
                end
                1: put(a, enc_i(6'h08, rs, rt, 16'($urandom())));
                2: put(a, enc_i(6'h23, 0, rt, 16'('h400 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3))));
                3: put(a, enc_i(6'h2B, 0, rt, 16'('h400 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3))));
                4: begin
                    if ($urandom_range(0, 1) == 1) rt = rs;
                    put(a, enc_i(6'h04, rs, rt, 16'($urandom_range(0, 3))));
                end
                default: put(a, {6'h02, 26'((a + 32'd4) >> 2) + 26'($urandom_range(0, 3))});
            endcase
            a += 4;
        end
        for (int i = 0; i < 4; i++) begin
            put(a, enc_r(6'h20, 0, 0, 0, 0)); a += 4;
        end
        for (int r = 1; r < 8; r++) begin
            put(a, enc_i(6'h2B, 0, r, 16'('h440 + 4 * r))); a += 4;
        end
        put(a, HALT_OP);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        bit seen;
        xfer_t x;
        reset = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = '0; mmem[i] = '0;
        end
        for (int i = 0; i < 32; i++) mregs[i] = '0;

        // addi/addi/add with zero-wait memory
        put(32'h40, enc_i(6'h08, 0, 1, 16'd5));
        put(32'h44, enc_i(6'h08, 0, 2, 16'd7));
        put(32'h48, enc_r(6'h20, 1, 2, 3, 0));
        put(32'h4C, HALT_OP);
        run_prog(0);

        // stores/loads, taken and untaken beq, sub/slt, j with 3 wait states
        put(32'h40, enc_i(6'h2B, 0, 3, 16'd8));
        put(32'h44, enc_i(6'h23, 0, 4, 16'd8));
        put(32'h48, enc_i(6'h04, 1, 1, 16'd2));
        put(32'h4C, enc_i(6'h08, 0, 5, 16'd1));
        put(32'h50, enc_i(6'h08, 0, 5, 16'd2));
        put(32'h54, enc_i(6'h04, 1, 2, 16'd1));
        put(32'h58, enc_i(6'h2B, 0, 4, 16'd12));
        put(32'h5C, enc_r(6'h22, 1, 2, 6, 0));
        put(32'h60, enc_r(6'h2A, 6, 1, 7, 0));
        put(32'h64, {6'h02, 26'h1C});
        put(32'h68, enc_i(6'h08, 0, 5, 16'd3));
        put(32'h6C, enc_i(6'h08, 0, 5, 16'd4));
        put(32'h70, enc_i(6'h2B, 0, 7, 16'd16));
        put(32'h74, HALT_OP);
        run_prog(3);

        // reset while a lw data request is stalled
        put(32'h40, enc_i(6'h08, 0, 4, 16'd99));
        put(32'h44, enc_i(6'h23, 0, 4, 16'h400));
        put(32'h48, HALT_OP);
        put(32'h400, 32'h1234_5678);
        exp_xfer.delete();
        x = '{we: 1'b0, addr: 32'h40, wdata: '0}; exp_xfer.push_back(x);
        x = '{we: 1'b0, addr: 32'h44, wdata: '0}; exp_xfer.push_back(x);
        waits_cfg  = 0;
        stall_data = 1'b1;
        do_reset(2);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (mem_req && !mem_we && mem_addr == 32'h400) seen = 1'b1;
        end
        check("stall_seen", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        check("stall_req_held", 32'(mem_req), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_req", 32'(mem_req), 32'd0);
        check("midrst_pc", pc, RESET_PC);
        check("midrst_addr", mem_addr, RESET_PC);
        check("midrst_retired", retired, 32'd0);
        stall_data = 1'b0;
        mregs[4] = 32'd99;

        // r4 must still hold 99 from before the abandoned load
        put(32'h40, enc_i(6'h2B, 0, 4, 16'h408));
        put(32'h44, HALT_OP);
        run_prog(1);

        for (int p = 0; p < 6; p++) begin
            gen_random();
            run_prog(int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS top.
- Executes the same MIPS-I subset through a control FSM. One shared datapath (ALU, register file, IR/A/B/ALUOut/MDR holding registers) is reused across states.
- Instruction and data traffic share one external memory port with a req/ready handshake, so wait-state memories are supported.
- Adds retired-instruction counting and a halt state on illegal opcodes, for use as the processor core under a memory/bus wrapper.

Parameters:
- ADDR_W, 32, PC and mem_addr width (legal range 8..32). PC arithmetic wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset. Must be word aligned.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- mem_req  out  1  memory request, held until accepted
- mem_we  out  1  1 = write (sw), 0 = read
- mem_addr  out  ADDR_W  byte address; bits [1:0] always 0
- mem_wdata  out  32  store data
- mem_rdata  in  32  read data, valid in the cycle mem_ready=1
- mem_ready  in  1  completes the pending request
- pc  out  ADDR_W  debug: current PC
- instruction  out  32  debug: IR contents
- alu_out  out  32  debug: ALUOut register
- reg_write_data  out  32  debug: data being written to the register file
- retired  out  CNT_W  count of completed instructions
- halted  out  1  core stopped on an illegal instruction

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=FETCH, pc=RESET_PC.
  - IR, A, B, ALUOut, MDR, retired, halted, mem_req, mem_we all 0.
  - Register file contents are not reset.
  - Reset mid-request: mem_req drops the cycle after reset is sampled. The memory must tolerate the abandoned request.
- Handshake:
  - While mem_req=1, mem_addr, mem_we and mem_wdata are stable.
  - A transfer completes on the edge where mem_req=1 and mem_ready=1. mem_req deasserts the next cycle unless a new request starts.
  - mem_ready while mem_req=0 is ignored.
- Supported ISA: add, sub, and, or, slt, sll (R-type, op 0); lw 0x23; sw 0x2B; beq 0x04; addi 0x08; j 0x02.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: req read at pc. On ready: IR<=mem_rdata, pc<=pc+4. Next state DECODE.
  - DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=pc+(sext(imm)<<2).
    - op j: pc<={pc[ADDR_W-1:28], target, 2'b00} (truncated to ADDR_W), retire, go to FETCH.
    - Unknown op or funct: go to HALT.
  - EXEC:
    - R-type: ALUOut<=A op B (sll uses B<<shamt).
    - lw/sw/addi: ALUOut<=A+sext(imm).
    - beq: if A==B then pc<=ALUOut. Retire, go to FETCH.
  - MEM:
    - lw: req read at ALUOut; on ready MDR<=mem_rdata, go to WB.
    - sw: req write of B to ALUOut; on ready retire, go to FETCH.
  - WB: rf[dest]<=ALUOut (R: rd; addi: rt) or MDR (lw: rt). Retire, go to FETCH.
  - HALT: absorbing until reset. halted=1, mem_req=0.
- Register file: writes to r0 are discarded and r0 always reads 0. The write occurs at the WB edge and is visible in the next instruction's DECODE.
- Arithmetic: 32-bit two's complement, overflow ignored. slt is a signed compare.
- Address rules: mem_addr uses ALUOut[ADDR_W-1:0] with bits [1:0] forced to 0. Misaligned addresses are silently truncated.
- Cycle counts with zero-wait memory (ready in the same cycle as req): j 2, beq 3, sw 4, R-type/addi 4, lw 5. Each wait cycle adds 1.
- Retirement: retired increments by exactly 1 on each retire event and wraps at 2^CNT_W. It never increments in HALT.
- reg_write_data shows the WB mux output in every state.

Test Plan:
- Reset with RESET_PC=0x40, hold reset=0 for 2 cycles -> pc=0x40, retired=0, halted=0, mem_req=0. First request after release has mem_addr=0x40.
- addi r1,r0,5; addi r2,r0,7; add r3,r1,r2 with zero-wait memory -> r3=12 (reg_write_data=12 in WB), retired=3 after 12 cycles.
- sw r3,8(r0) then lw r4,8(r0), with memory inserting 3 wait cycles on every request -> write of 12 to addr 8; r4=12; mem_addr/mem_wdata stable throughout each wait period.
- beq r1,r1,+2 at pc=0x10 -> pc=0x1C after 3 cycles. beq r1,r2 (5≠7) -> pc=0x14.
- Opcode 0x3F -> halted=1 after DECODE; mem_req stays 0 for 20 cycles; retired unchanged. Then pulse reset -> normal fetch resumes.
- Assert reset while a lw data request is stalled (mem_ready=0) -> mem_req=0 on the next cycle, state=FETCH, destination register unchanged.
